data_path: RTL and testbench
============================

# data_path

Datapath for the 8-bit CPU: holds IR, MAR, PC, A, B and CCR, routes data over Bus1/Bus2, and computes ALU results and NZVC flags. It sits between the control unit and memory.
- Consumes the control unit's load, increment and select strobes.
- Returns IR and CCR_Result, which the control unit decodes and branches on.
- Drives address and write data to memory and accepts read data from it.

## Interface
- No parameters; data width fixed at 8 bits, flag width at 4.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; clears all registers
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  in  1 each  register strobes from the control unit
- ALU_Sel  in  3  ALU operation select
- Bus1_Sel  in  2  Bus1 source: 00 PC, 01 A, 10 B, 11 8'h00
- Bus2_Sel  in  2  Bus2 source: 00 ALU result, 01 Bus1, 10 from_memory, 11 8'h00
- from_memory  in  8  memory read data, combinational from memory at address
- IR  out  8  instruction register
- CCR_Result  out  4  {V,N,Z,C}; bit0 C, bit1 Z, bit2 N, bit3 V
- address  out  8  equals MAR register
- to_memory  out  8  equals Bus1 (memory write data; write strobe goes directly from control unit to memory)

## Operation
- Buses (combinational):
  - Bus1 per Bus1_Sel.
  - Bus2 per Bus2_Sel.
- ALU (combinational):
  - Operands: X = Bus1, Y = B register.
  - 8-bit result R plus 4 flags.
- ALU ops, computed in 9 bits:
  - 000 ADD: R=X+Y; C=carry out; V=(X7==Y7)&&(R7!=X7).
  - 001 SUB: R=X−Y; C=borrow (X<Y unsigned); V=(X7!=Y7)&&(R7!=X7).
  - 010 AND, 011 OR, 100 XOR: R=X op Y; C=0, V=0.
  - 101 INC: R=X+1; C=(X==8'hFF); V=(X==8'h7F).
  - 110 DEC: R=X−1; C=(X==8'h00) (borrow); V=(X==8'h80).
  - 111 NOT: R=~X; C=0, V=0.
- N=R7 and Z=(R==0) for every op.
- Registers, on rising Clk:
  - IR, MAR, A, B load Bus2 when their strobe is 1; otherwise hold.
  - PC: PC_Load loads Bus2; else PC_Inc gives PC+1, wrapping 8'hFF→8'h00; else hold.
  - CCR: CCR_Load captures the current ALU flags {V,N,Z,C}; otherwise hold.
  - Loads are independent; any combination may assert in one cycle, all reading the same pre-edge Bus2 value.
- Simultaneous PC_Load and PC_Inc: PC_Load wins; PC = Bus2, no increment.
- Self-reference, e.g. A_Load with Bus1_Sel=A, Bus2_Sel=ALU: A takes the ALU result of the old A. No combinational loop, since Bus1 reads registers only.
- Reset:
  - When Reset=1 at a rising edge, IR, MAR, PC, A, B, CCR all become 0, regardless of strobes.
  - Reset mid-sequence discards any pending loads of that edge.
- Reset values of outputs:
  - IR=8'h00, CCR_Result=4'h0, address=8'h00.
  - to_memory=8'h00 when Bus1_Sel=PC.

## Timing
- Bus1, Bus2, ALU result, flags, to_memory: combinational, same-cycle from selects and register contents.
- Every register: 1-cycle latency; the value is visible after the rising edge where its strobe was high.
- from_memory is sampled at the edge; memory must present data for the current address within the same cycle.
  - Fetch: MAR_Load at edge n; IR_Load with Bus2_Sel=10 at edge n+1 captures mem[MAR].
- CCR_Result changes only on CCR_Load edges or Reset; a branch decision in the control unit sees flags from the prior CCR_Load.

## Test plan
- Reset: preload A=8'h55, PC=8'h10. Assert Reset for one edge → IR, MAR, PC, A, B, CCR all 0. Asserting all strobes during Reset still gives 0.
- Fetch/PC:
  - PC=8'hFF, PC_Inc → 8'h00.
  - PC_Load+PC_Inc with Bus2=ALU=8'h3C → PC=8'h3C.
  - MAR_Load (Bus1=PC, Bus2=Bus1) then IR_Load (Bus2=mem) with mem[8'h00]=8'h86 → address=8'h00, IR=8'h86.
- ADD flags, each with A_Load and CCR_Load:
  - A=8'h7F, B=8'h01 → A=8'h80, CCR=4'b1100 (V,N).
  - A=8'hFF, B=8'h01 → A=8'h00, CCR=4'b0011 (Z,C).
- SUB/INC/DEC:
  - SUB A=8'h01,B=8'h02 → 8'hFF, CCR=4'b0101 (N,C).
  - INC A=8'h7F → 8'h80, CCR=4'b1100.
  - DEC A=8'h00 → 8'hFF, CCR=4'b0101.
  - DEC A=8'h80 → 8'h7F, CCR=4'b1000.
- Logic:
  - AND 8'hF0&8'h0F → 8'h00, CCR=4'b0010.
  - XOR 8'hAA^8'hFF → 8'h55, CCR=4'b0000.
  - NOT B (Bus1=B, ALU_Sel=111, B_Load) with B=8'h00 → B=8'hFF, CCR=4'b0100.
- Store path: Bus1_Sel=A with A=8'h5A → to_memory=8'h5A the same cycle. CCR_Load=0 across 5 ALU ops → CCR_Result unchanged.

Source files
------------

// File: rtl/data_path.sv
// 8-bit CPU datapath: IR, MAR, PC, A, B, CCR registers, two source buses and
// a combinational ALU producing an 8-bit result with {V,N,Z,C} flags.
module data_path (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       IR_Load,
    input  logic       MAR_Load,
    input  logic       PC_Load,
    input  logic       PC_Inc,
    input  logic       A_Load,
    input  logic       B_Load,
    input  logic       CCR_Load,
    input  logic [2:0] ALU_Sel,
    input  logic [1:0] Bus1_Sel,
    input  logic [1:0] Bus2_Sel,
    input  logic [7:0] from_memory,
    output logic [7:0] IR,
    output logic [3:0] CCR_Result,
    output logic [7:0] address,
    output logic [7:0] to_memory
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_DEC = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    logic [7:0] ir_reg, mar, pc, a_reg, b_reg;
    logic [3:0] ccr;
    logic [7:0] bus1, bus2;
    logic [8:0] wide;
    logic [7:0] alu_r;
    logic       flag_v, flag_c;
    logic [3:0] alu_flags;

    // Bus1 only ever sources registers, so self-referencing loads cannot loop.
    always_comb begin
        case (Bus1_Sel)
            2'b00:   bus1 = pc;
            2'b01:   bus1 = a_reg;
            2'b10:   bus1 = b_reg;
            default: bus1 = 8'h00;
        endcase
    end

    always_comb begin
        wide   = 9'd0;
        flag_v = 1'b0;
        flag_c = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                wide   = {1'b0, bus1} + {1'b0, b_reg};
                flag_c = wide[8];
                flag_v = (bus1[7] == b_reg[7]) && (wide[7] != bus1[7]);
            end
            OP_SUB: begin
                wide   = {1'b0, bus1} - {1'b0, b_reg};
                flag_c = wide[8];
                flag_v = (bus1[7] != b_reg[7]) && (wide[7] != bus1[7]);
            end
            OP_AND: wide = {1'b0, bus1 & b_reg};
            OP_OR:  wide = {1'b0, bus1 | b_reg};
            OP_XOR: wide = {1'b0, bus1 ^ b_reg};
            OP_INC: begin
                wide   = {1'b0, bus1} + 9'd1;
                flag_c = wide[8];
                flag_v = (bus1 == 8'h7F);
            end
            OP_DEC: begin
                wide   = {1'b0, bus1} - 9'd1;
                flag_c = wide[8];
                flag_v = (bus1 == 8'h80);
            end
            OP_NOT: wide = {1'b0, ~bus1};
            default: wide = 9'd0;
        endcase
    end

    assign alu_r     = wide[7:0];
    assign alu_flags = {flag_v, alu_r[7], (alu_r == 8'h00), flag_c};

    always_comb begin
        case (Bus2_Sel)
            2'b00:   bus2 = alu_r;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = from_memory;
            default: bus2 = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ir_reg <= 8'h00;
            mar    <= 8'h00;
            pc     <= 8'h00;
            a_reg  <= 8'h00;
            b_reg  <= 8'h00;
            ccr    <= 4'h0;
        end else begin
            if (IR_Load)  ir_reg <= bus2;
            if (MAR_Load) mar    <= bus2;
            if (A_Load)   a_reg  <= bus2;
            if (B_Load)   b_reg  <= bus2;
            if (CCR_Load) ccr    <= alu_flags;
            // A direct load overrides a same-cycle increment.
            if (PC_Load)     pc <= bus2;
            else if (PC_Inc) pc <= pc + 8'd1;
        end
    end

    assign IR         = ir_reg;
    assign CCR_Result = ccr;
    assign address    = mar;
    assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Scoreboarded bench for data_path: directed corner cases then random control
// words, checked against an arithmetic reference model of the datapath.
module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       IR_Load = 1'b0, MAR_Load = 1'b0, PC_Load = 1'b0, PC_Inc = 1'b0;
    logic       A_Load = 1'b0, B_Load = 1'b0, CCR_Load = 1'b0;
    logic [2:0] ALU_Sel = 3'd0;
    logic [1:0] Bus1_Sel = 2'd0, Bus2_Sel = 2'd0;
    logic [7:0] from_memory;
    logic [7:0] IR, address, to_memory;
    logic [3:0] CCR_Result;

    logic [7:0] mem [256];

    typedef struct packed {
        logic       rst;
        logic       ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld, ccr_ld;
        logic [2:0] alu;
        logic [1:0] b1, b2;
    } ctl_t;

    typedef struct packed {
        logic       chk;
        logic [7:0] ir, addr, tomem;
        logic [3:0] ccr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [7:0] m_ir, m_mar, m_pc, m_a, m_b;
    logic [3:0] m_ccr;
    bit         m_known = 0;

    data_path dut (
        .Clk(Clk), .Reset(Reset),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .from_memory(from_memory),
        .IR(IR), .CCR_Result(CCR_Result), .address(address), .to_memory(to_memory)
    );

    assign from_memory = mem[address];

    always #5 Clk = ~Clk;

    // Reference ALU from the arithmetic definitions: returns {V,N,Z,C,R}.
    function automatic logic [11:0] ref_alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, res, sres;
        logic c, v;
        logic [7:0] r;
        ux = int'(x); uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        c = 0; v = 0; res = 0;
        case (op)
            3'd0: begin res = ux + uy; c = (res > 255); sres = sx + sy; v = (sres > 127 || sres < -128); end
            3'd1: begin res = ux - uy; c = (ux < uy);   sres = sx - sy; v = (sres > 127 || sres < -128); end
            3'd2: res = ux & uy;
            3'd3: res = ux | uy;
            3'd4: res = ux ^ uy;
            3'd5: begin res = ux + 1; c = (ux == 255); v = (ux == 127); end
            3'd6: begin res = ux - 1; c = (ux == 0);   v = (ux == 128); end
            default: res = 255 - ux;
        endcase
        r = 8'(res);
        return {v, r[7], (r == 8'h00), c, r};
    endfunction

    function automatic logic [7:0] ref_bus1(input logic [1:0] s);
        case (s)
            2'd0: return m_pc;
            2'd1: return m_a;
            2'd2: return m_b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        return c;
    endfunction

    // One clock cycle: apply controls just after the edge, queue the expected
    // outputs for this cycle, then advance the model across the coming edge.
    task automatic drive(input ctl_t c, input bit wr, input logic [7:0] wv);
        exp_t e;
        logic [7:0]  b1v, b2v;
        logic [11:0] alu;
        @(posedge Clk);
        #2;
        if (wr) mem[m_mar] = wv;
        Reset = c.rst; IR_Load = c.ir_ld; MAR_Load = c.mar_ld; PC_Load = c.pc_ld;
        PC_Inc = c.pc_inc; A_Load = c.a_ld; B_Load = c.b_ld; CCR_Load = c.ccr_ld;
        ALU_Sel = c.alu; Bus1_Sel = c.b1; Bus2_Sel = c.b2;
        b1v = ref_bus1(c.b1);
        e.chk = m_known; e.ir = m_ir; e.addr = m_mar; e.tomem = b1v; e.ccr = m_ccr;
        q.push_back(e);
        if (c.rst) begin
            m_ir = 0; m_mar = 0; m_pc = 0; m_a = 0; m_b = 0; m_ccr = 0; m_known = 1;
        end else if (m_known) begin
            alu = ref_alu(c.alu, b1v, m_b);
            case (c.b2)
                2'd0: b2v = alu[7:0];
                2'd1: b2v = b1v;
                2'd2: b2v = mem[m_mar];
                default: b2v = 8'h00;
            endcase
            if (c.ir_ld)  m_ir  = b2v;
            if (c.mar_ld) m_mar = b2v;
            if (c.a_ld)   m_a   = b2v;
            if (c.b_ld)   m_b   = b2v;
            if (c.ccr_ld) m_ccr = alu[11:8];
            if (c.pc_ld)       m_pc = b2v;
            else if (c.pc_inc) m_pc = 8'(int'(m_pc) + 1);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // which: 0 A, 1 B, 2 PC; value comes in through memory at the current MAR.
    task automatic load(input int which, input logic [7:0] v);
        ctl_t c;
        c = idle(); c.b2 = 2'd2;
        if (which == 0) c.a_ld = 1;
        else if (which == 1) c.b_ld = 1;
        else c.pc_ld = 1;
        drive(c, 1, v);
    endtask

    task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string nm);
        ctl_t c;
        c = idle(); c.b1 = sel;
        drive(c, 0, 8'h00);
        #1 chk(nm, to_memory, exp);
    endtask

    task automatic alu_t(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] eccr, input string nm);
        ctl_t c;
        load(0, a);
        load(1, b);
        c = idle(); c.b1 = 2'd1; c.alu = op; c.b2 = 2'd0; c.a_ld = 1; c.ccr_ld = 1;
        drive(c, 0, 8'h00);
        peek(2'd1, er, {nm, "_result"});
        chk({nm, "_ccr"}, {4'h0, CCR_Result}, {4'h0, eccr});
    endtask

    // Monitor: every cycle the DUT presents a fresh set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    chk("sb_IR", IR, e.ir);
                    chk("sb_address", address, e.addr);
                    chk("sb_to_memory", to_memory, e.tomem);
                    chk("sb_CCR", {4'h0, CCR_Result}, {4'h0, e.ccr});
                end
            end
        end
    end

    initial begin
        ctl_t c;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        c = idle(); c.rst = 1;
        drive(c, 0, 8'h00);
        load(0, 8'h55);
        load(2, 8'h10);
        peek(2'd1, 8'h55, "preload_A");
        c = '1; c.rst = 1;
        drive(c, 0, 8'h00);
        peek(2'd0, 8'h00, "reset_PC");
        chk("reset_IR", IR, 8'h00);
        chk("reset_address", address, 8'h00);
        chk("reset_CCR", {4'h0, CCR_Result}, 8'h00);
        peek(2'd1, 8'h00, "reset_A");
        peek(2'd2, 8'h00, "reset_B");

        c = idle(); c.mar_ld = 1; c.b1 = 2'd0; c.b2 = 2'd1;
        drive(c, 1, 8'h86);
        c = idle(); c.ir_ld = 1; c.b2 = 2'd2;
        drive(c, 0, 8'h00);
        peek(2'd0, 8'h00, "fetch_PC");
        chk("fetch_IR", IR, 8'h86);
        chk("fetch_address", address, 8'h00);

        load(2, 8'hFF);
        c = idle(); c.pc_inc = 1;
        drive(c, 0, 8'h00);
        peek(2'd0, 8'h00, "pc_wrap");

        load(0, 8'h3C);
        load(1, 8'h00);
        c = idle(); c.b1 = 2'd1; c.alu = 3'd0; c.b2 = 2'd0; c.pc_ld = 1; c.pc_inc = 1;
        drive(c, 0, 8'h00);
        peek(2'd0, 8'h3C, "pc_load_wins");

        alu_t(3'd0, 8'h7F, 8'h01, 8'h80, 4'b1100, "add_ovf");
        alu_t(3'd0, 8'hFF, 8'h01, 8'h00, 4'b0011, "add_carry");
        alu_t(3'd1, 8'h01, 8'h02, 8'hFF, 4'b0101, "sub_borrow");
        alu_t(3'd5, 8'h7F, 8'h00, 8'h80, 4'b1100, "inc_ovf");
        alu_t(3'd6, 8'h00, 8'h00, 8'hFF, 4'b0101, "dec_zero");
        alu_t(3'd6, 8'h80, 8'h00, 8'h7F, 4'b1000, "dec_ovf");
        alu_t(3'd2, 8'hF0, 8'h0F, 8'h00, 4'b0010, "and_zero");
        alu_t(3'd4, 8'hAA, 8'hFF, 8'h55, 4'b0000, "xor");

        load(1, 8'h00);
        c = idle(); c.b1 = 2'd2; c.alu = 3'd7; c.b2 = 2'd0; c.b_ld = 1; c.ccr_ld = 1;
        drive(c, 0, 8'h00);
        peek(2'd2, 8'hFF, "not_B");
        chk("not_ccr", {4'h0, CCR_Result}, 8'h04);

        load(0, 8'h5A);
        peek(2'd1, 8'h5A, "store_path");
        for (int i = 0; i < 5; i++) begin
            c = idle(); c.b1 = 2'd1; c.alu = 3'(i); c.b2 = 2'd0; c.a_ld = 1;
            drive(c, 0, 8'h00);
        end
        peek(2'd0, 8'h3C, "hold_PC");
        chk("ccr_hold", {4'h0, CCR_Result}, 8'h04);

        for (int i = 0; i < 600; i++) begin
            c = ctl_t'($urandom);
            c.rst = ($urandom_range(0, 40) == 0);
            drive(c, ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        drive(idle(), 0, 8'h00);
        repeat (3) @(negedge Clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
